ks_pipe_subtractor: RTL and testbench



---
 rtl/ks_pkg.sv | 21 ++
 rtl/ks_prefix_level.sv | 25 ++
 rtl/ks_pipe_subtractor.sv | 143 ++++++++++++++
 tb/tb_ks_pipe_subtractor.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared definitions for the pipelined Kogge-Stone subtractor: default width,
// prefix-depth and span helpers, and the generate/propagate pair type.
package ks_pkg;

  localparam int KS_WIDTH = 32;

  typedef struct packed {
    logic [KS_WIDTH-1:0] g;
    logic [KS_WIDTH-1:0] p;
  } gp_t;

  function automatic int log2w(input int w);
    return $clog2(w);
  endfunction

  // Distance between combined bit positions at a given tree level (level >= 1).
  function automatic int span(input int level);
    return 1 << (level - 1);
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational radix-2 Kogge-Stone prefix level: every bit at or above SPAN
// absorbs the group SPAN positions below it; lower bits pass straight through.
module ks_prefix_level
  import ks_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH,
  parameter int SPAN  = 1
) (
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] g_next,
  output logic [WIDTH-1:0] p_next
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= SPAN) begin : g_comb
      assign g_next[i] = g[i] | (p[i] & g[i-SPAN]);
      assign p_next[i] = p[i] & p[i-SPAN];
    end else begin : g_pass
      assign g_next[i] = g[i];
      assign p_next[i] = p[i];
    end
  end

endmodule

// File: rtl/ks_pipe_subtractor.sv
// Three-stage Kogge-Stone subtractor (A - B - Bin) with valid/ready on both sides.
// Define KS_SUB_CMP_EN to add the registered lt_u / lt_s / eq comparison outputs.
module ks_pipe_subtractor
  import ks_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH,
  parameter int SPLIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             Bout,
  output logic             ovf,
  output logic             zero
`ifdef KS_SUB_CMP_EN
  ,
  output logic             lt_u,
  output logic             lt_s,
  output logic             eq
`endif
);

  localparam int DEPTH = log2w(WIDTH);

  logic vld_p1, vld_p2, vld_p3;
  logic adv_p1, adv_p2, adv_p3;

  // A stage loads whenever it is empty or its successor is moving.
  assign adv_p3    = ~vld_p3 | out_ready;
  assign adv_p2    = ~vld_p2 | adv_p3;
  assign adv_p1    = ~vld_p1 | adv_p2;
  assign in_ready  = adv_p1;
  assign out_valid = vld_p3;

  // Stage 1: generate/propagate of A + ~B with carry-in ~Bin.
  logic [WIDTH-1:0] g_p1, p_p1;
  logic             c0_p1, sa_p1, sb_p1;
`ifdef KS_SUB_CMP_EN
  logic             bin_p1, bin_p2;
`endif

  always_ff @(posedge clk) begin
    if (adv_p1 && in_valid) begin
      g_p1  <= A & ~B;
      p_p1  <= A ^ ~B;
      c0_p1 <= ~Bin;
      sa_p1 <= A[WIDTH-1];
      sb_p1 <= B[WIDTH-1];
`ifdef KS_SUB_CMP_EN
      bin_p1 <= Bin;
`endif
    end
  end

  logic [WIDTH-1:0] ga [0:SPLIT];
  logic [WIDTH-1:0] pa [0:SPLIT];
  assign ga[0] = g_p1;
  assign pa[0] = p_p1;

  for (genvar l = 1; l <= SPLIT; l++) begin : g_lvl_lo
    ks_prefix_level #(.WIDTH(WIDTH), .SPAN(span(l))) u_lvl (
      .g(ga[l-1]), .p(pa[l-1]), .g_next(ga[l]), .p_next(pa[l])
    );
  end

  // Stage 2: partial prefix groups plus the untouched bitwise propagate.
  logic [WIDTH-1:0] g_p2, p_p2, p0_p2;
  logic             c0_p2, sa_p2, sb_p2;

  always_ff @(posedge clk) begin
    if (adv_p2 && vld_p1) begin
      g_p2  <= ga[SPLIT];
      p_p2  <= pa[SPLIT];
      p0_p2 <= p_p1;
      c0_p2 <= c0_p1;
      sa_p2 <= sa_p1;
      sb_p2 <= sb_p1;
`ifdef KS_SUB_CMP_EN
      bin_p2 <= bin_p1;
`endif
    end
  end

  logic [WIDTH-1:0] gb [SPLIT:DEPTH];
  logic [WIDTH-1:0] pb [SPLIT:DEPTH];
  assign gb[SPLIT] = g_p2;
  assign pb[SPLIT] = p_p2;

  for (genvar l = SPLIT + 1; l <= DEPTH; l++) begin : g_lvl_hi
    ks_prefix_level #(.WIDTH(WIDTH), .SPAN(span(l))) u_lvl (
      .g(gb[l-1]), .p(pb[l-1]), .g_next(gb[l]), .p_next(pb[l])
    );
  end

  logic [WIDTH-1:0] carry, diff_nxt;
  logic             cout, ovf_nxt;

  assign carry    = {gb[DEPTH][WIDTH-2:0] | (pb[DEPTH][WIDTH-2:0] & {(WIDTH-1){c0_p2}}), c0_p2};
  assign cout     = gb[DEPTH][WIDTH-1] | (pb[DEPTH][WIDTH-1] & c0_p2);
  assign diff_nxt = p0_p2 ^ carry;
  assign ovf_nxt  = (sa_p2 ^ sb_p2) & (diff_nxt[WIDTH-1] ^ sa_p2);

  // Stage 3: result registers, cleared by reset along with the valid chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      diff   <= '0;
      Bout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
`ifdef KS_SUB_CMP_EN
      lt_u   <= 1'b0;
      lt_s   <= 1'b0;
      eq     <= 1'b0;
`endif
    end else begin
      if (adv_p1) vld_p1 <= in_valid;
      if (adv_p2) vld_p2 <= vld_p1;
      if (adv_p3) vld_p3 <= vld_p2;
      if (adv_p3 && vld_p2) begin
        diff <= diff_nxt;
        Bout <= ~cout;
        ovf  <= ovf_nxt;
        zero <= ~|diff_nxt;
`ifdef KS_SUB_CMP_EN
        lt_u <= ~cout;
        lt_s <= diff_nxt[WIDTH-1] ^ ovf_nxt;
        eq   <= ~|diff_nxt & ~bin_p2;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ks_pipe_subtractor.sv
// Scoreboard bench for ks_pipe_subtractor: expected results come from a plain
// integer-arithmetic model and are matched against each output transfer in order.
module tb_ks_pipe_subtractor;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         Bout, ovf, zero;
`ifdef KS_SUB_CMP_EN
  logic         lt_u, lt_s, eq;
`endif

  ks_pipe_subtractor dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .Bout(Bout), .ovf(ovf), .zero(zero)
`ifdef KS_SUB_CMP_EN
    , .lt_u(lt_u), .lt_s(lt_s), .eq(eq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] diff;
    logic bout, ovf, zero, lt_u, lt_s, eq;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   or_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    res_t   r;
    longint ua, ub, sa, sb, bl, d, s;
    ua = a;  ub = b;  bl = bin;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    d  = ua - ub - bl;
    s  = sa - sb - bl;
    r.diff = d[W-1:0];
    r.bout = (d < 0);
    r.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    r.zero = (r.diff == '0);
`ifdef KS_SUB_CMP_EN
    r.lt_u = (ua < ub + bl);
    r.lt_s = (s < 0);
    r.eq   = (a == b) && !bin;
`else
    r.lt_u = 1'b0;
    r.lt_s = 1'b0;
    r.eq   = 1'b0;
`endif
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r.diff = diff;
    r.bout = Bout;
    r.ovf  = ovf;
    r.zero = zero;
`ifdef KS_SUB_CMP_EN
    r.lt_u = lt_u;
    r.lt_s = lt_s;
    r.eq   = eq;
`else
    r.lt_u = 1'b0;
    r.lt_s = 1'b0;
    r.eq   = 1'b0;
`endif
    return r;
  endfunction

  // Input-side monitor: a transfer at the coming edge enqueues its expectation.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready)
      exp_q.push_back(model(A, B, Bin));
  end

  // Output-side monitor: pops on each output transfer, checks hold while stalled.
  bit   held = 1'b0;
  res_t held_v;
  res_t act;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      act = observed();
      if (held) chk("stall_hold", {out_valid, act}, {1'b1, held_v});
      held = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%h required=no_beat", act);
          end else begin
            chk("result", act, exp_q.pop_front());
          end
        end else begin
          held   = 1'b1;
          held_v = act;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (or_mode == 0) out_ready = 1'b1;
      else if (or_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    A = a;  B = b;  Bin = bin;  in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept_within_200");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [W-1:0] ra, rb;

    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", 64'({diff, Bout, ovf, zero}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Single beat: latency and basic result.
    A = 32'd5;  B = 32'd3;  Bin = 1'b0;  in_valid = 1'b1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat++;
      if (out_valid) break;
    end
    chk("latency", 64'(lat), 64'd3);
    chk("basic_diff", 64'(diff), 64'd2);
    chk("basic_flags", 64'({Bout, ovf, zero}), 64'd0);
    drain();

    // Boundary vectors.
    send(32'h0000_0000, 32'h0000_0001, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0);
    send(32'h1234_5678, 32'h1234_5677, 1'b1);
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(32'h0000_0000, 32'h0000_0000, 1'b1);
    in_valid = 1'b0;
    drain();

    // Backpressure: stall the output while a 10-beat stream keeps arriving.
    or_mode = 2;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_diff", 64'(diff), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_stale", 64'(out_valid), 64'd0);

    // Randomised traffic with random output backpressure.
    or_mode = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        ra = $urandom;
        case ($urandom_range(0, 7))
          0:       rb = ra;
          1:       rb = ra + 32'd1;
          2:       rb = {ra[W-1], ~ra[W-2:0]};
          default: rb = $urandom;
        endcase
        send(ra, rb, 1'($urandom_range(0, 1)));
      end else begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    or_mode = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
